echo_effect: RTL and testbench
==============================

ECHO_EFFECT -- requirements
Module: echo_effect

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 16, sample width in bits (two's complement).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, log2 of delay depth; depth N = 2**ADDR_WIDTH samples.
REQ-003 The block SHALL have parameter ATT_SHIFT, default 1, arithmetic right-shift applied to the delayed sample.
REQ-004 Ports SHALL be as follows:
- clk  in  1  single clock; one clock.
- reset  in  1  reset, synchronous and active-high.
- i_enable  in  1  echo on when 1; pass-through when 0; sampled at the start of each sample transaction.
- i_data_ready  in  1  upstream FIFO not empty.
- i_data  in  D_WIDTH  upstream FIFO read data, valid the cycle after o_read_enable.
- o_read_enable  out  1  one-cycle pop strobe to the upstream FIFO.
- o_data  out  D_WIDTH  processed sample.
- o_data_valid  out  1  one-cycle strobe qualifying o_data; push to the downstream FIFO.

Function
REQ-005 The FSM SHALL have states CLEAR, IDLE, REQ, CAPT, MIX and OUT.
REQ-006 CLEAR SHALL write zero to delay RAM addresses 0..N-1, one per cycle, then go to IDLE; o_read_enable SHALL stay 0 throughout CLEAR.
REQ-007 IDLE SHALL go to REQ when i_data_ready=1, else stay in IDLE.
REQ-008 REQ SHALL assert o_read_enable for exactly one cycle, latch i_enable into en_q and go to CAPT.
REQ-009 CAPT SHALL register i_data into x_q, issue a RAM read at wr_ptr and go to MIX.
REQ-010 The RAM read latency SHALL be 1 cycle, so the read returns the sample written N transactions earlier.
REQ-011 MIX SHALL compute the result y and write y to RAM[wr_ptr], then go to OUT.
- en_q=1: y = sat(x_q + (d >>> ATT_SHIFT)).
- en_q=0: y = x_q.
REQ-012 The sum SHALL be formed at D_WIDTH+1 bits and saturated to [-2**(D_WIDTH-1), 2**(D_WIDTH-1)-1].
REQ-013 OUT SHALL drive o_data=y with o_data_valid=1 for one cycle, increment wr_ptr modulo N (N-1 wraps to 0) and go to IDLE.
REQ-014 Latency SHALL be 3 cycles from the o_read_enable cycle to the o_data_valid cycle.
REQ-015 Throughput SHALL be at most one sample per 5 cycles.
REQ-016 o_read_enable SHALL never be asserted unless i_data_ready=1 in the preceding IDLE cycle.
REQ-017 At most one read SHALL be outstanding; i_data_ready deasserting mid-transaction SHALL be ignored until IDLE.
REQ-018 o_data SHALL hold its last value between o_data_valid strobes.
REQ-019 The block SHALL apply no backpressure from downstream; the downstream FIFO is sized to accept every strobe.

Reset
REQ-020 reset SHALL be synchronous and active-high; while reset=1 at a clk edge the block SHALL load state=CLEAR, clear address=0, wr_ptr=0, x_q=0, en_q=0, o_data=0, o_read_enable=0 and o_data_valid=0.
REQ-021 reset asserted in any state, including mid-CLEAR or mid-transaction, SHALL abort the transaction; no o_data_valid SHALL be issued for it and a full CLEAR sweep SHALL restart.

Structure
REQ-022 The shared package audio_pkg SHALL hold:
- the state enumeration typedef;
- the default D_WIDTH;
- the saturation limit constants.
REQ-023 The delay memory SHALL be a separate sub-module, delay_ram, with one synchronous write port and one synchronous read port (1-cycle latency), no reset and BRAM-inferable.
REQ-024 The saturating adder SHALL be a function in audio_pkg, not a module.

Verification (ADDR_WIDTH=3, N=8, ATT_SHIFT=1)
REQ-025 Bench SHALL check reset then idle: reset high 2 cycles, i_data_ready=1 -> no o_read_enable for 8 CLEAR cycles; first o_read_enable on the following IDLE->REQ transition.
REQ-026 Bench SHALL check the impulse: en=1, feed 1000 then zeros -> outputs 1000, 0 x7, 500, 0 x7, 250, 0 x7, 125.
REQ-027 Bench SHALL check saturation: en=1, feed 30000 repeatedly -> output 9 = 32767 (30000+15000 clamped); negative case -30000 -> -32768.
REQ-028 Bench SHALL check bypass: en=0, feed 7, -3, 32767 -> outputs 7, -3, 32767 with exactly 3-cycle latency each.
REQ-029 Bench SHALL check reset mid-transaction: reset asserted in MIX -> no o_data_valid; after re-CLEAR, impulse 1000 yields 1000 and no stale echo at sample 9.
REQ-030 Bench SHALL check FIFO handshake: i_data_ready toggled randomly -> exactly one o_read_enable per o_data_valid, none while i_data_ready=0 in IDLE.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types, constants and arithmetic helpers
// for the audio effect blocks.
package audio_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    REQ,
    CAPT,
    MIX,
    OUT
  } state_e;

  localparam int D_WIDTH_DEF = 16;
  localparam int SAT_MAX = 2**(D_WIDTH_DEF-1) - 1;
  localparam int SAT_MIN = -(2**(D_WIDTH_DEF-1));

  // Add two w-bit signed values one bit wider,
  // then clamp back into the w-bit range.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      return 32'(hi);
    end
    if (s < lo) begin
      return 32'(lo);
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Echo delay line storage: one write port and
// one registered read port, no reset.
module delay_ram
  import audio_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [D_WIDTH-1:0]    wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [D_WIDTH-1:0]    rdata_o
);

  logic [D_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [D_WIDTH-1:0] rdata_q;

  // Synchronous write and one-cycle read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/echo_effect.sv
// Feedback echo: pops one sample, mixes in the
// attenuated sample from N transactions ago.
module echo_effect
  import audio_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int ADDR_WIDTH = 12,
  parameter int ATT_SHIFT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic               i_data_ready,
  input  logic [D_WIDTH-1:0] i_data,
  output logic               o_read_enable,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_data_valid
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic signed [D_WIDTH-1:0] x_q, x_d;
  logic en_q, en_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic rd_en_q, rd_en_d;
  logic vld_q, vld_d;

  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_wa;
  logic [D_WIDTH-1:0]    ram_wd;
  logic [D_WIDTH-1:0]    ram_rd;

  logic signed [D_WIDTH-1:0] echo;
  logic signed [D_WIDTH-1:0] sum_s;
  logic [D_WIDTH-1:0]        y;

  delay_ram #(
    .D_WIDTH   (D_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_wa),
    .wdata_i(ram_wd),
    .re_i   (ram_re),
    .raddr_i(ptr_q),
    .rdata_o(ram_rd)
  );

  assign echo  = $signed(ram_rd) >>> ATT_SHIFT;
  assign sum_s = D_WIDTH'(sat_add(32'(x_q), 32'(echo), D_WIDTH));
  assign y     = en_q ? sum_s : x_q;

  // Registers; outputs are registered so they
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      ptr_q   <= '0;
      x_q     <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      rd_en_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      en_q    <= en_d;
      data_q  <= data_d;
      rd_en_q <= rd_en_d;
      vld_q   <= vld_d;
    end
  end

  // Sequencer: zero sweep, then one sample per
  // pop / capture / mix / output round.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    en_d    = en_q;
    data_d  = data_q;
    rd_en_d = 1'b0;
    vld_d   = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    ram_wa  = ptr_q;
    ram_wd  = y;
    unique case (state_q)
      CLEAR: begin
        ram_we = 1'b1;
        ram_wa = clr_q;
        ram_wd = '0;
        clr_d  = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (i_data_ready) begin
          rd_en_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        en_d    = i_enable;
        state_d = CAPT;
      end
      CAPT: begin
        x_d     = i_data;
        ram_re  = 1'b1;
        state_d = MIX;
      end
      MIX: begin
        ram_we  = 1'b1;
        data_d  = y;
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        ptr_d   = ptr_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign o_read_enable = rd_en_q;
  assign o_data        = data_q;
  assign o_data_valid  = vld_q;

endmodule

// File: tb/tb_echo_effect.sv
// Bench for echo_effect: vector tables, hand
// sequences and random handshake vs a model.
module tb_echo_effect;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_data_ready = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_read_enable;
  logic [15:0] o_data;
  logic        o_data_valid;

  echo_effect #(
    .D_WIDTH   (16),
    .ADDR_WIDTH(3),
    .ATT_SHIFT (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_data_ready (i_data_ready),
    .i_data       (i_data),
    .o_read_enable(o_read_enable),
    .o_data       (o_data),
    .o_data_valid (o_data_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit rst;
    bit en;
    int x;
    int exp;
  } vec_t;

  vec_t tbl[$];

  // Reference: ring of past outputs, one slot
  // per sample position modulo N.
  int mem_m[N];
  int ptr_m;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) mem_m[i] = 0;
    ptr_m = 0;
  endfunction

  function automatic int model_step(int x, bit en);
    int y;
    y = x;
    if (en) begin
      y = x + (mem_m[ptr_m] >>> 1);
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
    end
    mem_m[ptr_m] = y;
    ptr_m = (ptr_m + 1) % N;
    return y;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_data_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (N + 1) tick();
    model_clear();
  endtask

  task automatic send(input int x, input bit en,
                      output int out, output int lat);
    bit ok;
    ok = 0;
    out = 0;
    lat = 0;
    i_enable = en;
    i_data_ready = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      if (o_read_enable) ok = 1;
    end
    i_data_ready = 1'b0;
    if (!ok) begin
      chk("rd_timeout", 0, 1);
      return;
    end
    i_data = 16'(x);
    ok = 0;
    for (int c = 1; c <= 10 && !ok; c++) begin
      tick();
      if (o_data_valid) begin
        ok = 1;
        lat = c;
        out = int'($signed(o_data));
      end
    end
    if (!ok) chk("vld_timeout", 0, 1);
  endtask

  int out, lat, ones, vcnt;
  int rd_cnt, vld_cnt, xr;
  bit er;
  int exp_q[$];

  initial begin
    // Impulse and its decaying echoes.
    for (int k = 0; k < 25; k++) begin
      int e;
      e = 0;
      if (k == 0) e = 1000;
      if (k == 8) e = 500;
      if (k == 16) e = 250;
      if (k == 24) e = 125;
      tbl.push_back('{k == 0, 1'b1,
                      (k == 0) ? 1000 : 0, e});
    end
    // Positive and negative saturation.
    for (int k = 0; k < 9; k++)
      tbl.push_back('{k == 0, 1'b1, 30000,
                      (k == 8) ? 32767 : 30000});
    for (int k = 0; k < 9; k++)
      tbl.push_back('{k == 0, 1'b1, -30000,
                      (k == 8) ? -32768 : -30000});
    // Bypass.
    tbl.push_back('{1'b1, 1'b0, 7, 7});
    tbl.push_back('{1'b0, 1'b0, -3, -3});
    tbl.push_back('{1'b0, 1'b0, 32767, 32767});

    // Reset, then the CLEAR sweep blocks pops.
    reset = 1'b1;
    i_data_ready = 1'b1;
    repeat (2) tick();
    chk("rst_rd_en", int'(o_read_enable), 0);
    chk("rst_valid", int'(o_data_valid), 0);
    chk("rst_data", int'(o_data), 0);
    reset = 1'b0;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      tick();
      ones += int'(o_read_enable);
    end
    chk("clear_no_rd", ones, 0);
    tick();
    chk("first_rd", int'(o_read_enable), 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].x, tbl[i].en, out, lat);
      chk($sformatf("vec%0d_data", i),
          out, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, 3);
    end

    // Reset while in MIX drops the sample.
    do_reset();
    i_enable = 1'b1;
    i_data_ready = 1'b1;
    ones = 0;
    for (int c = 0; c < 20 && ones == 0; c++) begin
      tick();
      ones = int'(o_read_enable);
    end
    chk("mid_rd_seen", ones, 1);
    i_data_ready = 1'b0;
    i_data = 16'(1000);
    tick();
    tick();
    reset = 1'b1;
    vcnt = 0;
    repeat (2) begin
      tick();
      vcnt += int'(o_data_valid);
    end
    reset = 1'b0;
    repeat (N + 4) begin
      tick();
      vcnt += int'(o_data_valid);
    end
    chk("mid_no_valid", vcnt, 0);
    model_clear();
    for (int k = 0; k < 10; k++) begin
      send((k == 0) ? 1000 : 0, 1'b1, out, lat);
      chk($sformatf("post_rst%0d", k), out,
          (k == 0) ? 1000 : (k == 8) ? 500 : 0);
    end

    // Random ready toggling against the model.
    do_reset();
    rd_cnt = 0;
    vld_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 3000 && vld_cnt < 40; c++) begin
      tick();
      if (o_read_enable) begin
        rd_cnt++;
        chk("rd_needs_ready", int'(i_data_ready), 1);
        xr = int'($urandom_range(0, 65535)) - 32768;
        er = 1'($urandom_range(0, 1));
        i_data = 16'(xr);
        i_enable = er;
        exp_q.push_back(model_step(xr, er));
      end
      if (o_data_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0)
          chk("rand_unexpected", 1, 0);
        else
          chk("rand_data", int'($signed(o_data)),
              exp_q.pop_front());
      end
      i_data_ready = 1'($urandom_range(0, 1));
    end
    i_data_ready = 1'b0;
    repeat (10) begin
      tick();
      rd_cnt += int'(o_read_enable);
      if (o_data_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0)
          chk("rand_unexpected", 1, 0);
        else
          chk("rand_data", int'($signed(o_data)),
              exp_q.pop_front());
      end
    end
    chk("rand_rd_eq_vld", rd_cnt, vld_cnt);
    chk("rand_enough", int'(vld_cnt >= 40), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
